// File: rtl/memory_oam_dma.sv
// OAM DMA engine and CPU/bus arbiter; optional DMA_CPU_LOCKOUT_EN selects
// hardware-style CPU lockout instead of cycle stealing.
module memory_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          XFER_LEN     = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  input  logic        cpu_nread,
  input  logic        cpu_nwrite,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in,
  output logic        bus_nread,
  output logic        bus_nwrite,
  output logic        dma_active
);

  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  src_reg;
  logic [7:0]  count;
  logic [7:0]  data_latch;
  logic [7:0]  last_out;
  logic [7:0]  src_eff;
  logic        reg_hit;
  logic        reg_wr;
  logic        cpu_req;
  logic        cpu_grant;
  logic        hold;
  logic        xfer;

  assign reg_hit    = cpu_address == DMA_REG_ADDR;
  assign reg_wr     = reg_hit & ~cpu_nwrite;
  assign cpu_req    = ~cpu_nread | ~cpu_nwrite;
  assign xfer       = (state == READ) | (state == WRITE);
  assign dma_active = state != IDLE;

  // Echo RAM sources fold back onto WRAM (E0 -> C0)
  assign src_eff = (src_reg >= 8'hE0) ? (src_reg & 8'hDF) : src_reg;

`ifdef DMA_CPU_LOCKOUT_EN
  assign hold      = 1'b0;
  assign cpu_grant = state == IDLE;
`else
  assign hold      = xfer & cpu_req & ~reg_hit;
  assign cpu_grant = (state == IDLE) | (state == START) | hold;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (reg_wr) begin
      state_nx = START;
    end else if (!hold) begin
      unique case (state)
        IDLE:    state_nx = IDLE;
        START:   state_nx = READ;
        READ:    state_nx = WRITE;
        WRITE:   state_nx = (count == LAST) ? IDLE : READ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_reg    <= 8'h00;
      count      <= 8'h00;
      data_latch <= 8'h00;
      last_out   <= 8'h00;
    end else begin
      if (reg_wr) begin
        src_reg <= cpu_data_out;
        count   <= 8'h00;
      end else if (!hold && state == WRITE) begin
        count <= count + 8'd1;
      end
      if (!hold && state == READ) data_latch <= bus_data_in;
      if (!bus_nwrite) last_out <= bus_data_out;
    end
  end

  always_comb begin
    bus_address  = cpu_address;
    bus_nread    = 1'b1;
    bus_nwrite   = 1'b1;
    bus_data_oe  = 1'b0;
    bus_data_out = last_out;
    unique case (1'b1)
      cpu_grant & reg_hit: ;
      cpu_grant & ~reg_hit: begin
        bus_nread    = cpu_nread;
        bus_nwrite   = cpu_nwrite;
        bus_data_out = cpu_data_out;
        bus_data_oe  = ~cpu_nwrite;
      end
      ~cpu_grant & (state == READ): begin
        bus_address = {src_eff, 8'h00} + {8'h00, count};
        bus_nread   = 1'b0;
      end
      ~cpu_grant & (state == WRITE): begin
        bus_address  = OAM_BASE + {8'h00, count};
        bus_nwrite   = 1'b0;
        bus_data_oe  = 1'b1;
        bus_data_out = data_latch;
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_data_in = bus_data_in;
    if (reg_hit) begin
      cpu_data_in = src_reg;
    end else begin
`ifdef DMA_CPU_LOCKOUT_EN
      if (dma_active) cpu_data_in = 8'hFF;
`endif
    end
  end

endmodule
